// File: rtl/arb_pkg.sv
// Shared types, sizes and the next-owner search for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan last_idx+1 .. last_idx+4 (mod 4); descending loop so the earliest hit wins.
  function automatic pick_t next_owner(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] last_idx,
                                       input logic             exclude_owner);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int d = N_REQ; d >= 1; d--) begin
      cand = last_idx + IDX_W'(d);
      if (req[cand] && !(exclude_owner && (cand == last_idx))) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder2_4.sv
// 2-to-4 one-hot decoder with an output enable.
module decoder2_4 (
  input  logic       en_i,
  input  logic [1:0] idx_i,
  output logic [3:0] onehot_o
);

  assign onehot_o = en_i ? (4'b0001 << idx_i) : 4'b0000;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-owner hold limit under contention.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  pick_t            pick;
  logic             take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= 2'd3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // In BUSY last_idx equals the owner, so excluding it makes pick.found mean "someone else waits".
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    take       = 1'b0;
    pick       = next_owner(req, last_idx_q, state_q == BUSY);

    case (state_q)
      IDLE: begin
        if (pick.found) take = 1'b1;
      end
      BUSY: begin
        if (!req[gnt_idx_q]) begin
          if (pick.found) begin
            take = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_idx_d  = '0;
            hold_cnt_d = '0;
          end
        end else if (pick.found && (hold_cnt_q >= HOLD_MAX)) begin
          take = 1'b1;
        end else if (hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d    = BUSY;
      gnt_idx_d  = pick.idx;
      last_idx_d = pick.idx;
      hold_cnt_d = CNT_W'(1);
    end
  end

  assign gnt_valid = (state_q == BUSY);
  assign gnt_idx   = gnt_idx_q;

  decoder2_4 u_dec (
    .en_i     (gnt_valid),
    .idx_i    (gnt_idx_q),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (MAX_HOLD 1, 3, 8) share one request vector.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;

  logic [3:0] gnt_w [3];
  logic [1:0] idx_w [3];
  logic       vld_w [3];

  int tests = 0;
  int fails = 0;

  int maxh  [3] = '{1, 3, 8};
  int owner [3];
  int last  [3];
  int held  [3];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(1)) u_h1 (.clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(vld_w[0]));
  rr_arbiter4 #(.MAX_HOLD(3)) u_h3 (.clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(vld_w[1]));
  rr_arbiter4 #(.MAX_HOLD(8)) u_h8 (.clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(vld_w[2]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first requester after lst, optionally skipping lst itself.
  function automatic int rr_pick(input int lst, input logic [3:0] r, input bit skip_lst);
    for (int d = 1; d <= 4; d++) begin
      int c;
      c = (lst + d) % 4;
      if (r[c] && !(skip_lst && c == lst)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      owner[k] = -1;
      last[k]  = 3;
      held[k]  = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r);
    for (int k = 0; k < 3; k++) begin
      int nxt;
      nxt = rr_pick(last[k], r, owner[k] >= 0);
      if (owner[k] < 0) begin
        if (nxt >= 0) begin owner[k] = nxt; last[k] = nxt; held[k] = 1; end
      end else if (!r[owner[k]] || (nxt >= 0 && held[k] >= maxh[k])) begin
        if (nxt >= 0) begin owner[k] = nxt; last[k] = nxt; held[k] = 1; end
        else begin owner[k] = -1; held[k] = 0; end
      end else if (held[k] < maxh[k]) begin
        held[k]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      logic [1:0] ei;
      eg = (owner[k] < 0) ? 4'b0000 : 4'(1 << owner[k]);
      ei = (owner[k] < 0) ? 2'd0 : 2'(owner[k]);
      chk($sformatf("%s.h%0d.gnt", tag, maxh[k]), gnt_w[k], eg);
      chk($sformatf("%s.h%0d.idx", tag, maxh[k]), {2'b00, idx_w[k]}, {2'b00, ei});
      chk($sformatf("%s.h%0d.vld", tag, maxh[k]), {3'b000, vld_w[k]}, {3'b000, owner[k] >= 0});
    end
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(req);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rot [5];
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held with every requester active
    reset_n = 1'b0;
    req     = 4'b1111;
    model_reset();
    #1;
    check_all("rst_async");
    step("rst");
    step("rst");
    chk("rst.gnt", gnt_w[2], 4'b0000);

    // Full contention: MAX_HOLD=1 rotates every cycle, first grant to requester 0
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("contend");
      chk($sformatf("contend.h1.c%0d", i), gnt_w[0], rot[i]);
    end
    chk("contend.h8.first", gnt_w[2], 4'b0001);
    for (int i = 0; i < 6; i++) step("contend");
    req = 4'b0000;
    step("drain");
    step("drain");
    chk("drain.idle", gnt_w[2], 4'b0000);

    // Single requester 2 for five cycles
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step("single");
      chk($sformatf("single.h8.c%0d", i), gnt_w[2], 4'b0100);
    end
    req = 4'b0000;
    step("single_drop");
    chk("single.h8.after", gnt_w[2], 4'b0000);
    step("single_drop");

    // Hold limit: requester 0 owns, requester 2 arrives in grant cycle 1
    req = 4'b0001;
    step("hold");
    chk("hold.h3.g1", gnt_w[1], 4'b0001);
    req = 4'b0101;
    step("hold");
    chk("hold.h3.g2", gnt_w[1], 4'b0001);
    step("hold");
    chk("hold.h3.g3", gnt_w[1], 4'b0001);
    step("hold");
    chk("hold.h3.rot", gnt_w[1], 4'b0100);
    req = 4'b0000;
    step("hold_drain");
    step("hold_drain");

    // No contention: requester 0 keeps the grant indefinitely
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step("solo");
      chk($sformatf("solo.h3.c%0d", i), gnt_w[1], 4'b0001);
    end
    req = 4'b0000;
    step("solo_drain");

    // Back-to-back release: owner 1 drops while requester 3 waits
    req = 4'b0010;
    step("b2b");
    chk("b2b.h8.own1", gnt_w[2], 4'b0010);
    req = 4'b1000;
    step("b2b");
    chk("b2b.h8.own3", gnt_w[2], 4'b1000);
    chk("b2b.h3.own3", gnt_w[1], 4'b1000);
    req = 4'b0000;
    step("b2b_drain");

    // Randomized traffic, sticky-ish requests
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else req = req ^ (4'b0001 << $urandom_range(0, 3)) & 4'($urandom | $urandom);
      step("rand");
    end
    req = 4'b0000;
    step("rand_drain");
    step("rand_drain");

    // Reset mid-grant takes effect between edges
    req = 4'b0100;
    step("midrst");
    chk("midrst.h8.pre", gnt_w[2], 4'b0100);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    req = 4'b1111;
    step("midrst_hold");
    reset_n = 1'b1;
    step("midrst_rel");
    chk("midrst.h8.first", gnt_w[2], 4'b0001);
    step("midrst_rel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
